axilite4_regfile_slave: RTL and testbench
=========================================

# axilite4_regfile_slave

Parametrised AXI-Lite 4 slave that maps a bank of `NUM_REGS` read/write registers onto the standard five-channel read/write port set. It adds configurable data/address width, independent address/data acceptance, error responses for misaligned or out-of-range accesses, and a flattened register output bus for downstream logic. It sits behind the system interconnect as the generic control/status register block for accelerator configuration.

## Interface
- `ADDR_W`, 32: address width in bits.
- `DATA_W`, 32: data width in bits; must be 32 or 64.
- `NUM_REGS`, 16: number of registers, from 1 to 2^(ADDR_W-log2(DATA_W/8)).
- `clk` in 1: clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `readAddr_addr` in ADDR_W: read byte address.
- `readAddr_valid` in 1, `readAddr_ready` out 1: read-address handshake.
- `readData_data` out DATA_W: read data.
- `readData_resp` out 2: read response; 2'b00 OKAY, 2'b10 SLVERR.
- `readData_valid` out 1, `readData_ready` in 1: read-data handshake.
- `writeAddr_addr` in ADDR_W: write byte address.
- `writeAddr_valid` in 1, `writeAddr_ready` out 1: write-address handshake.
- `writeData_data` in DATA_W: write data.
- `writeData_strb` in DATA_W/8: byte strobes. Present only with `AXIL_STRB_EN`.
- `writeData_valid` in 1, `writeData_ready` out 1: write-data handshake.
- `writeResp_msg` out 32: bits [1:0] carry the response code (same encoding as `readData_resp`); bits [31:2] are 0.
- `writeResp_valid` out 1, `writeResp_ready` in 1: write-response handshake.
- `regs_out` out NUM_REGS*DATA_W: register i is at bits [i*DATA_W +: DATA_W].

## Operation
- **Decode:** word index = `addr >> log2(DATA_W/8)`.
  - Access is in range when index < NUM_REGS and the low byte-offset bits are 0.
  - Otherwise the response is SLVERR, no register changes, and read data is 0.
- **Read FSM:**
  - R_IDLE: `readAddr_ready`=1. On `readAddr_valid`, capture data and response, go to R_DATA.
  - R_DATA: `readData_valid`=1, data and response held stable. On `readData_ready`, return to R_IDLE.
- **Write FSM:**
  - W_IDLE: address and data are captured independently. `writeAddr_ready` = !aw_held; `writeData_ready` = !w_held.
  - When both are held (including the cycle both handshake together), the register commits and the FSM enters W_RESP.
  - W_RESP: both readies are 0, `writeResp_valid`=1. On `writeResp_ready`, clear the held flags and return to W_IDLE.
- **Simultaneous read and write to the same register:**
  - If the read is captured in the commit cycle, it returns the old value.
  - A read captured one cycle later returns the new value.
- The read and write FSMs are fully independent; neither stalls the other.
- **Reset:**
  - All registers and `regs_out` = 0.
  - Both FSMs go to IDLE and held flags clear.
  - `readAddr_ready`=`writeAddr_ready`=`writeData_ready`=1; all valid outputs 0.
  - `readData_data`=0, `readData_resp`=0, `writeResp_msg`=0.
  - Reset mid-transaction abandons it; a pending write is not committed.

## Timing
- Read: AR handshake at cycle T; `readData_valid` at T+1. Throughput is one read per 2 cycles with ready held high.
- Write: last of AW/W handshakes at T; register and `regs_out` update at the T→T+1 edge; `writeResp_valid` at T+1. Throughput is one write per 2 cycles.
- Valid outputs stay high and the associated data stays stable until the matching ready is sampled high.
- All outputs are registered or decoded from FSM state only; there is no combinational path from input to output.

## Configuration
- **`AXIL_STRB_EN` defined:**
  - The `writeData_strb` port exists.
  - Byte lane k of the target register is written only when strb[k]=1.
  - A write with all strobes 0 still returns OKAY and changes nothing.
- **Undefined:**
  - The port is absent.
  - Every in-range write updates the full word.

## Test plan
- **Reset:** assert `rst` mid-write (AW held, W not yet sent) → after release, readies=1, valids=0, reading addr 0x0 returns 0x00000000 with OKAY.
- **Write/read, AW before W:** AW addr 0x8 at cycle 0, W 0xDEADBEEF at cycle 3 → response OKAY at cycle 4; read of 0x8 returns 0xDEADBEEF; `regs_out` word 2 = 0xDEADBEEF.
- **Errors** (NUM_REGS=16, DATA_W=32):
  - Write to 0x40 → SLVERR, registers unchanged.
  - Read from 0x41 → SLVERR with data 0.
- **Backpressure:** hold `readData_ready`=0 for 5 cycles → `readData_valid` and data stay stable; `readAddr_ready`=0 throughout.
- **Same-cycle collision:** write 0x5 to reg 3, commit in the same cycle as an AR to 0xC → read returns the old value 0x0; the next read returns 0x5.
- **Strobes (`AXIL_STRB_EN`):** reg 1 = 0x11223344; write 0xAABBCCDD with strb 4'b0101 → reads back 0x11BB33DD.

Source files
------------

// File: rtl/axilite4_regfile_slave.sv
// axilite4_regfile_slave: AXI-Lite 4 slave exposing NUM_REGS read/write
// registers, with SLVERR on misaligned or out-of-range accesses and a flat
// register output bus for downstream logic.
// Optional feature macro: AXIL_STRB_EN (adds writeData_strb byte-lane enables).
module axilite4_regfile_slave #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    // read address channel
    input  logic [ADDR_W-1:0]            readAddr_addr,
    input  logic                         readAddr_valid,
    output logic                         readAddr_ready,
    // read data channel
    output logic [DATA_W-1:0]            readData_data,
    output logic [1:0]                   readData_resp,
    output logic                         readData_valid,
    input  logic                         readData_ready,
    // write address channel
    input  logic [ADDR_W-1:0]            writeAddr_addr,
    input  logic                         writeAddr_valid,
    output logic                         writeAddr_ready,
    // write data channel
    input  logic [DATA_W-1:0]            writeData_data,
`ifdef AXIL_STRB_EN
    input  logic [DATA_W/8-1:0]          writeData_strb,
`endif
    input  logic                         writeData_valid,
    output logic                         writeData_ready,
    // write response channel
    output logic [31:0]                  writeResp_msg,
    output logic                         writeResp_valid,
    input  logic                         writeResp_ready,
    // flattened register bank
    output logic [NUM_REGS*DATA_W-1:0]   regs_out
);

    localparam int BYTES = DATA_W / 8;
    localparam int OFF_W = $clog2(BYTES);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic {R_IDLE, R_DATA} r_state_t;
    typedef enum logic {W_IDLE, W_RESP} w_state_t;

    // An access hits a register only when word-aligned and inside the bank.
    function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
        return ((a >> OFF_W) < ADDR_W'(NUM_REGS)) && (a[OFF_W-1:0] == '0);
    endfunction

    // ------------------------------------------------------------------
    // Read path
    // ------------------------------------------------------------------
    r_state_t              r_state_q, r_state_d;
    logic [DATA_W-1:0]     rdata_q;
    logic [1:0]            rresp_q;
    logic [ADDR_W-1:0]     rd_idx;
    logic [DATA_W-1:0]     rd_word;
    logic                  ar_hs;

    assign rd_idx = readAddr_addr >> OFF_W;
    assign ar_hs  = (r_state_q == R_IDLE) && readAddr_valid;

    // Select the addressed register from the flat bus (pre-edge value, so a
    // read captured in a write's commit cycle sees the old contents).
    always_comb begin
        rd_word = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (rd_idx == ADDR_W'(i)) begin
                rd_word = regs_out[i*DATA_W +: DATA_W];
            end
        end
    end

    // Read FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state_q <= R_IDLE;
        end else begin
            r_state_q <= r_state_d;
        end
    end

    // Read FSM next-state logic.
    always_comb begin
        r_state_d = r_state_q;
        case (r_state_q)
            R_IDLE:  if (readAddr_valid) r_state_d = R_DATA;
            R_DATA:  if (readData_ready) r_state_d = R_IDLE;
            default: r_state_d = R_IDLE;
        endcase
    end

    // Read FSM outputs, decoded from state only.
    always_comb begin
        readAddr_ready = (r_state_q == R_IDLE);
        readData_valid = (r_state_q == R_DATA);
    end

    // Capture read data and response at the address handshake; held until consumed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_q <= '0;
            rresp_q <= RESP_OKAY;
        end else if (ar_hs) begin
            rdata_q <= addr_ok(readAddr_addr) ? rd_word : '0;
            rresp_q <= addr_ok(readAddr_addr) ? RESP_OKAY : RESP_SLVERR;
        end
    end

    assign readData_data = rdata_q;
    assign readData_resp = rresp_q;

    // ------------------------------------------------------------------
    // Write path
    // ------------------------------------------------------------------
    w_state_t              w_state_q, w_state_d;
    logic                  aw_held_q, w_held_q;
    logic [ADDR_W-1:0]     awaddr_q;
    logic [DATA_W-1:0]     wdata_q;
    logic [1:0]            bresp_q;
    logic                  aw_hs, w_hs, commit, wr_ok;
    logic [ADDR_W-1:0]     wr_addr, wr_idx;
    logic [DATA_W-1:0]     wr_data, wr_mask;

    assign aw_hs   = (w_state_q == W_IDLE) && writeAddr_valid && !aw_held_q;
    assign w_hs    = (w_state_q == W_IDLE) && writeData_valid && !w_held_q;
    // Commit as soon as both halves are available, held or arriving now.
    assign commit  = (w_state_q == W_IDLE) && (aw_held_q || aw_hs) && (w_held_q || w_hs);
    assign wr_addr = aw_held_q ? awaddr_q : writeAddr_addr;
    assign wr_data = w_held_q ? wdata_q : writeData_data;
    assign wr_idx  = wr_addr >> OFF_W;
    assign wr_ok   = addr_ok(wr_addr);

`ifdef AXIL_STRB_EN
    logic [BYTES-1:0]      wstrb_q;
    logic [BYTES-1:0]      wr_strb;
    assign wr_strb = w_held_q ? wstrb_q : writeData_strb;

    // Strobes are captured alongside the data beat.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wstrb_q <= '0;
        end else if (w_hs) begin
            wstrb_q <= writeData_strb;
        end
    end

    for (genvar gi = 0; gi < BYTES; gi++) begin : g_mask
        assign wr_mask[gi*8 +: 8] = {8{wr_strb[gi]}};
    end
`else
    assign wr_mask = '1;
`endif

    // Write FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_state_q <= W_IDLE;
        end else begin
            w_state_q <= w_state_d;
        end
    end

    // Write FSM next-state logic.
    always_comb begin
        w_state_d = w_state_q;
        case (w_state_q)
            W_IDLE:  if (commit)          w_state_d = W_RESP;
            W_RESP:  if (writeResp_ready) w_state_d = W_IDLE;
            default: w_state_d = W_IDLE;
        endcase
    end

    // Write FSM outputs, decoded from state and held flags only.
    always_comb begin
        writeAddr_ready = (w_state_q == W_IDLE) && !aw_held_q;
        writeData_ready = (w_state_q == W_IDLE) && !w_held_q;
        writeResp_valid = (w_state_q == W_RESP);
    end

    // Independent AW/W capture, response code, and release after the B handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            aw_held_q <= 1'b0;
            w_held_q  <= 1'b0;
            awaddr_q  <= '0;
            wdata_q   <= '0;
            bresp_q   <= RESP_OKAY;
        end else begin
            if (aw_hs) begin
                aw_held_q <= 1'b1;
                awaddr_q  <= writeAddr_addr;
            end
            if (w_hs) begin
                w_held_q <= 1'b1;
                wdata_q  <= writeData_data;
            end
            if (commit) begin
                bresp_q <= wr_ok ? RESP_OKAY : RESP_SLVERR;
            end
            if ((w_state_q == W_RESP) && writeResp_ready) begin
                aw_held_q <= 1'b0;
                w_held_q  <= 1'b0;
            end
        end
    end

    assign writeResp_msg = {30'b0, bresp_q};

    // ------------------------------------------------------------------
    // Register bank: one storage word per register, merged by byte mask.
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
        logic [DATA_W-1:0] reg_q;

        // Update this register when an in-range commit targets it.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                reg_q <= '0;
            end else if (commit && wr_ok && (wr_idx == ADDR_W'(gi))) begin
                reg_q <= (reg_q & ~wr_mask) | (wr_data & wr_mask);
            end
        end

        assign regs_out[gi*DATA_W +: DATA_W] = reg_q;
    end

endmodule

// File: tb/tb_axilite4_regfile_slave.sv
// Directed testbench for axilite4_regfile_slave (default 32-bit, 16 regs).
// Define AXIL_STRB_EN for both files to exercise byte strobes.
module tb_axilite4_regfile_slave;

    localparam int ADDR_W   = 32;
    localparam int DATA_W   = 32;
    localparam int NUM_REGS = 16;

    logic                        clk = 1'b0;
    logic                        rst = 1'b1;
    logic [ADDR_W-1:0]           readAddr_addr = '0;
    logic                        readAddr_valid = 1'b0;
    logic                        readAddr_ready;
    logic [DATA_W-1:0]           readData_data;
    logic [1:0]                  readData_resp;
    logic                        readData_valid;
    logic                        readData_ready = 1'b0;
    logic [ADDR_W-1:0]           writeAddr_addr = '0;
    logic                        writeAddr_valid = 1'b0;
    logic                        writeAddr_ready;
    logic [DATA_W-1:0]           writeData_data = '0;
`ifdef AXIL_STRB_EN
    logic [DATA_W/8-1:0]         writeData_strb = '1;
`endif
    logic                        writeData_valid = 1'b0;
    logic                        writeData_ready;
    logic [31:0]                 writeResp_msg;
    logic                        writeResp_valid;
    logic                        writeResp_ready = 1'b0;
    logic [NUM_REGS*DATA_W-1:0]  regs_out;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    axilite4_regfile_slave #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_REGS(NUM_REGS)
    ) dut (
        .clk(clk),
        .rst(rst),
        .readAddr_addr(readAddr_addr),
        .readAddr_valid(readAddr_valid),
        .readAddr_ready(readAddr_ready),
        .readData_data(readData_data),
        .readData_resp(readData_resp),
        .readData_valid(readData_valid),
        .readData_ready(readData_ready),
        .writeAddr_addr(writeAddr_addr),
        .writeAddr_valid(writeAddr_valid),
        .writeAddr_ready(writeAddr_ready),
        .writeData_data(writeData_data),
`ifdef AXIL_STRB_EN
        .writeData_strb(writeData_strb),
`endif
        .writeData_valid(writeData_valid),
        .writeData_ready(writeData_ready),
        .writeResp_msg(writeResp_msg),
        .writeResp_valid(writeResp_valid),
        .writeResp_ready(writeResp_ready),
        .regs_out(regs_out)
    );

    // Full write transaction: AW and W presented together, B accepted at once.
    task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, output logic [1:0] resp);
        bit aw_done, w_done, hs_aw, hs_w;
        writeAddr_addr  = addr;
        writeData_data  = data;
`ifdef AXIL_STRB_EN
        writeData_strb  = strb;
`endif
        writeAddr_valid = 1'b1;
        writeData_valid = 1'b1;
        writeResp_ready = 1'b1;
        aw_done = 1'b0;
        w_done  = 1'b0;
        for (int c = 0; c < 20 && !(aw_done && w_done); c++) begin
            hs_aw = writeAddr_valid && writeAddr_ready;
            hs_w  = writeData_valid && writeData_ready;
            @(posedge clk); #1;
            if (hs_aw) begin writeAddr_valid = 1'b0; aw_done = 1'b1; end
            if (hs_w)  begin writeData_valid = 1'b0; w_done  = 1'b1; end
        end
        writeAddr_valid = 1'b0;
        writeData_valid = 1'b0;
        for (int c = 0; c < 20 && !writeResp_valid; c++) begin
            @(posedge clk); #1;
        end
        checks++;
        if (!writeResp_valid) begin
            errors++;
            $display("FAIL write_timeout addr=%h got writeResp_valid=0, required 1", addr);
            resp = 2'b11;
        end else begin
            resp = writeResp_msg[1:0];
        end
        $display("WRITE addr=%h data=%h strb=%b resp=%b", addr, data, strb, resp);
        @(posedge clk); #1;
    endtask

    // Full read transaction with readData_ready held high.
    task automatic axi_read(input logic [31:0] addr, output logic [31:0] data,
                            output logic [1:0] resp);
        bit done, hs;
        readAddr_addr  = addr;
        readAddr_valid = 1'b1;
        readData_ready = 1'b1;
        done = 1'b0;
        for (int c = 0; c < 20 && !done; c++) begin
            hs = readAddr_valid && readAddr_ready;
            @(posedge clk); #1;
            if (hs) done = 1'b1;
        end
        readAddr_valid = 1'b0;
        for (int c = 0; c < 20 && !readData_valid; c++) begin
            @(posedge clk); #1;
        end
        checks++;
        if (!readData_valid) begin
            errors++;
            $display("FAIL read_timeout addr=%h got readData_valid=0, required 1", addr);
            data = 32'hxxxxxxxx;
            resp = 2'b11;
        end else begin
            data = readData_data;
            resp = readData_resp;
        end
        $display("READ  addr=%h data=%h resp=%b", addr, data, resp);
        @(posedge clk); #1;
        readData_ready = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        logic [1:0]  r;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({readAddr_ready, writeAddr_ready, writeData_ready} !== 3'b111) begin
            errors++;
            $display("FAIL reset_readies got %b, required 111",
                     {readAddr_ready, writeAddr_ready, writeData_ready});
        end
        checks++;
        if ({readData_valid, writeResp_valid} !== 2'b00) begin
            errors++;
            $display("FAIL reset_valids got %b, required 00", {readData_valid, writeResp_valid});
        end
        checks++;
        if (readData_data !== 32'h0 || readData_resp !== 2'b00 || writeResp_msg !== 32'h0) begin
            errors++;
            $display("FAIL reset_outputs got rdata=%h rresp=%b bmsg=%h, required all 0",
                     readData_data, readData_resp, writeResp_msg);
        end
        checks++;
        if (regs_out !== '0) begin
            errors++;
            $display("FAIL reset_regs_out got nonzero %h, required 0", regs_out);
        end
        rst = 1'b0;
        @(posedge clk); #1;
        // Mid-write reset: AW accepted, W never sent.
        writeAddr_addr  = 32'h0;
        writeAddr_valid = 1'b1;
        @(posedge clk); #1;
        writeAddr_valid = 1'b0;
        checks++;
        if (writeAddr_ready !== 1'b0) begin
            errors++;
            $display("FAIL aw_held_ready got %b, required 0", writeAddr_ready);
        end
        rst = 1'b1;
        #2;
        checks++;
        if ({writeAddr_ready, writeData_ready, writeResp_valid} !== 3'b110) begin
            errors++;
            $display("FAIL midwrite_reset got aw_rdy,w_rdy,bvalid=%b, required 110",
                     {writeAddr_ready, writeData_ready, writeResp_valid});
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        axi_read(32'h0, d, r);
        checks++;
        if (d !== 32'h0 || r !== 2'b00) begin
            errors++;
            $display("FAIL reset_read0 got data=%h resp=%b, required 00000000 00", d, r);
        end
    endtask

    task automatic test_write_aw_first();
        logic [31:0] d;
        logic [1:0]  r;
        writeResp_ready = 1'b1;
        writeAddr_addr  = 32'h8;
        writeAddr_valid = 1'b1;
        @(posedge clk); #1;
        writeAddr_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({writeAddr_ready, writeData_ready, writeResp_valid} !== 3'b010) begin
            errors++;
            $display("FAIL aw_first_wait got aw_rdy,w_rdy,bvalid=%b, required 010",
                     {writeAddr_ready, writeData_ready, writeResp_valid});
        end
        writeData_data  = 32'hDEADBEEF;
`ifdef AXIL_STRB_EN
        writeData_strb  = 4'hF;
`endif
        writeData_valid = 1'b1;
        @(posedge clk); #1;
        writeData_valid = 1'b0;
        checks++;
        if (writeResp_valid !== 1'b1 || writeResp_msg !== 32'h0) begin
            errors++;
            $display("FAIL aw_first_resp got bvalid=%b msg=%h, required 1 00000000",
                     writeResp_valid, writeResp_msg);
        end
        checks++;
        if (regs_out[2*32 +: 32] !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL aw_first_regs_out got %h, required deadbeef", regs_out[2*32 +: 32]);
        end
        $display("WRITE addr=00000008 data=deadbeef (AW first) resp=%b", writeResp_msg[1:0]);
        @(posedge clk); #1;
        checks++;
        if (writeResp_valid !== 1'b0 || writeAddr_ready !== 1'b1) begin
            errors++;
            $display("FAIL aw_first_release got bvalid=%b aw_rdy=%b, required 0 1",
                     writeResp_valid, writeAddr_ready);
        end
        axi_read(32'h8, d, r);
        checks++;
        if (d !== 32'hDEADBEEF || r !== 2'b00) begin
            errors++;
            $display("FAIL aw_first_read got %h/%b, required deadbeef/00", d, r);
        end
    endtask

    task automatic test_write_w_first();
        logic [31:0] d;
        logic [1:0]  r;
        writeResp_ready = 1'b1;
        writeData_data  = 32'h0BADF00D;
`ifdef AXIL_STRB_EN
        writeData_strb  = 4'hF;
`endif
        writeData_valid = 1'b1;
        @(posedge clk); #1;
        writeData_valid = 1'b0;
        @(posedge clk); #1;
        writeAddr_addr  = 32'h14;
        writeAddr_valid = 1'b1;
        @(posedge clk); #1;
        writeAddr_valid = 1'b0;
        checks++;
        if (writeResp_valid !== 1'b1 || writeResp_msg !== 32'h0) begin
            errors++;
            $display("FAIL w_first_resp got bvalid=%b msg=%h, required 1 00000000",
                     writeResp_valid, writeResp_msg);
        end
        $display("WRITE addr=00000014 data=0badf00d (W first) resp=%b", writeResp_msg[1:0]);
        @(posedge clk); #1;
        axi_read(32'h14, d, r);
        checks++;
        if (d !== 32'h0BADF00D || r !== 2'b00) begin
            errors++;
            $display("FAIL w_first_read got %h/%b, required 0badf00d/00", d, r);
        end
    endtask

    task automatic test_errors();
        logic [NUM_REGS*DATA_W-1:0] snap;
        logic [31:0] d;
        logic [1:0]  r;
        snap = regs_out;
        axi_write(32'h40, 32'h12345678, 4'hF, r);
        checks++;
        if (r !== 2'b10) begin
            errors++;
            $display("FAIL err_write_range got resp=%b, required 10", r);
        end
        axi_write(32'h6, 32'h87654321, 4'hF, r);
        checks++;
        if (r !== 2'b10) begin
            errors++;
            $display("FAIL err_write_misaligned got resp=%b, required 10", r);
        end
        checks++;
        if (regs_out !== snap) begin
            errors++;
            $display("FAIL err_regs_unchanged got %h, required %h", regs_out, snap);
        end
        axi_read(32'h41, d, r);
        checks++;
        if (d !== 32'h0 || r !== 2'b10) begin
            errors++;
            $display("FAIL err_read got %h/%b, required 00000000/10", d, r);
        end
        // Last register is the in-range boundary.
        axi_write(32'h3C, 32'hA5A5A5A5, 4'hF, r);
        axi_read(32'h3C, d, r);
        checks++;
        if (d !== 32'hA5A5A5A5 || r !== 2'b00 || regs_out[15*32 +: 32] !== 32'hA5A5A5A5) begin
            errors++;
            $display("FAIL last_reg got %h/%b regs_out=%h, required a5a5a5a5/00",
                     d, r, regs_out[15*32 +: 32]);
        end
    endtask

    task automatic test_backpressure();
        logic [1:0] r;
        axi_write(32'h10, 32'hCAFEF00D, 4'hF, r);
        readAddr_addr  = 32'h10;
        readAddr_valid = 1'b1;
        readData_ready = 1'b0;
        @(posedge clk); #1;
        readAddr_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (readData_valid !== 1'b1 || readData_data !== 32'hCAFEF00D || readAddr_ready !== 1'b0) begin
                errors++;
                $display("FAIL backpressure cycle %0d got rvalid=%b data=%h ar_rdy=%b, required 1 cafef00d 0",
                         i, readData_valid, readData_data, readAddr_ready);
            end
            @(posedge clk); #1;
        end
        readData_ready = 1'b1;
        @(posedge clk); #1;
        readData_ready = 1'b0;
        checks++;
        if (readData_valid !== 1'b0 || readAddr_ready !== 1'b1) begin
            errors++;
            $display("FAIL backpressure_release got rvalid=%b ar_rdy=%b, required 0 1",
                     readData_valid, readAddr_ready);
        end
        $display("READ  addr=00000010 data=cafef00d (5-cycle backpressure)");
    endtask

    task automatic test_collision();
        logic [31:0] d;
        logic [1:0]  r;
        writeAddr_addr  = 32'hC;
        writeData_data  = 32'h5;
`ifdef AXIL_STRB_EN
        writeData_strb  = 4'hF;
`endif
        readAddr_addr   = 32'hC;
        writeAddr_valid = 1'b1;
        writeData_valid = 1'b1;
        readAddr_valid  = 1'b1;
        writeResp_ready = 1'b1;
        readData_ready  = 1'b1;
        @(posedge clk); #1;
        writeAddr_valid = 1'b0;
        writeData_valid = 1'b0;
        readAddr_valid  = 1'b0;
        checks++;
        if (readData_valid !== 1'b1 || readData_data !== 32'h0) begin
            errors++;
            $display("FAIL collision_old got rvalid=%b data=%h, required 1 00000000",
                     readData_valid, readData_data);
        end
        checks++;
        if (writeResp_valid !== 1'b1 || regs_out[3*32 +: 32] !== 32'h5) begin
            errors++;
            $display("FAIL collision_commit got bvalid=%b reg3=%h, required 1 00000005",
                     writeResp_valid, regs_out[3*32 +: 32]);
        end
        $display("COLLIDE write 0000000c=00000005, read returned %h", readData_data);
        @(posedge clk); #1;
        readData_ready = 1'b0;
        axi_read(32'hC, d, r);
        checks++;
        if (d !== 32'h5 || r !== 2'b00) begin
            errors++;
            $display("FAIL collision_new got %h/%b, required 00000005/00", d, r);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] vals [4];
        logic [31:0] d;
        logic [1:0]  r;
        vals[0] = 32'h01020304;
        vals[1] = 32'hFFFFFFFF;
        vals[2] = 32'h80000001;
        vals[3] = 32'h5A5A0F0F;
        for (int i = 0; i < 4; i++) begin
            axi_write(32'(24 + 4*i), vals[i], 4'hF, r);
            checks++;
            if (r !== 2'b00) begin
                errors++;
                $display("FAIL b2b_write %0d got resp=%b, required 00", i, r);
            end
        end
        for (int i = 0; i < 4; i++) begin
            axi_read(32'(24 + 4*i), d, r);
            checks++;
            if (d !== vals[i] || r !== 2'b00) begin
                errors++;
                $display("FAIL b2b_read %0d got %h/%b, required %h/00", i, d, r, vals[i]);
            end
        end
    endtask

`ifdef AXIL_STRB_EN
    task automatic test_strobe();
        logic [31:0] d;
        logic [1:0]  r;
        axi_write(32'h4, 32'h11223344, 4'hF, r);
        axi_write(32'h4, 32'hAABBCCDD, 4'b0101, r);
        axi_read(32'h4, d, r);
        checks++;
        if (d !== 32'h11BB33DD || r !== 2'b00) begin
            errors++;
            $display("FAIL strobe_merge got %h/%b, required 11bb33dd/00", d, r);
        end
        axi_write(32'h4, 32'h99999999, 4'b0000, r);
        checks++;
        if (r !== 2'b00 || regs_out[1*32 +: 32] !== 32'h11BB33DD) begin
            errors++;
            $display("FAIL strobe_zero got resp=%b reg1=%h, required 00 11bb33dd",
                     r, regs_out[1*32 +: 32]);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_write_aw_first();
        test_write_w_first();
        test_errors();
        test_backpressure();
        test_collision();
        test_back_to_back();
`ifdef AXIL_STRB_EN
        test_strobe();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Hard stop in case a transaction never completes.
    initial begin
        #200000;
        $display("FAIL global_timeout got simulation still running, required completion");
        $fatal(1, "timeout");
    end

endmodule
